// File: rtl/wb_trace_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_checker_if
// Description : Register-file writeback port of the single-cycle CPU
//               skeleton. The CPU side drives it (master); the trace checker
//               only observes it (slave).
//   wb_en   : ctrl_writeEnable
//   wb_reg  : ctrl_writeReg
//   wb_data : data_writeReg
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_trace_checker_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
);
  logic                      wb_en;
  logic [REG_ADDR_WIDTH-1:0] wb_reg;
  logic [DATA_WIDTH-1:0]     wb_data;

  modport master (output wb_en, output wb_reg, output wb_data);
  modport slave  (input  wb_en, input  wb_reg, input  wb_data);
endinterface
`default_nettype wire

// File: rtl/wb_trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_checker
// Description : Passive monitor for the CPU register-file writeback port.
//               Each accepted writeback is compared against a loadable table
//               of expected (register, data) pairs. Reports completion,
//               pass/fail, timeout, a saturating error count and the table
//               index of the first mismatch.
// Ports       :
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   load_en/addr/reg/data - table write (honoured in IDLE only)
//   num_expected, start - run length (clamped to DEPTH) and run trigger
//   wb (slave)          - observed writeback port
//   busy/done/pass/timed_out - decoded run status (registered)
//   err_count, wb_index, first_err_valid, first_err_idx - run results
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERR_WIDTH      = 8,
  parameter int IGNORE_R0      = 1
) (
  input  wire                           clock,
  input  wire                           reset,
  input  wire                           load_en,
  input  wire [$clog2(DEPTH)-1:0]       load_addr,
  input  wire [REG_ADDR_WIDTH-1:0]      load_reg,
  input  wire [DATA_WIDTH-1:0]          load_data,
  input  wire [$clog2(DEPTH+1)-1:0]     num_expected,
  input  wire                           start,
  wb_trace_checker_if.slave             wb,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timed_out,
  output logic [ERR_WIDTH-1:0]          err_count,
  output logic [$clog2(DEPTH+1)-1:0]    wb_index,
  output logic                          first_err_valid,
  output logic [$clog2(DEPTH)-1:0]      first_err_idx
);

  localparam int C_IDX_W   = $clog2(DEPTH);
  localparam int C_CNT_W   = $clog2(DEPTH+1);
  localparam int C_TMO_W   = $clog2(TIMEOUT_CYCLES+1);
  localparam int C_ENTRY_W = REG_ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   n_q, n_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic [C_CNT_W-1:0]   wbi_q, wbi_d;
  logic                 fev_q, fev_d;
  logic [C_IDX_W-1:0]   fei_q, fei_d;
  logic [C_TMO_W-1:0]   tmo_q, tmo_d;
  logic                 busy_q, done_q, pass_q, tmo_flag_q;

  // Expected table; deliberately not reset so it survives a reset between runs.
  logic [C_ENTRY_W-1:0] table_q [DEPTH];

  logic                 wb_acc;
  logic                 mismatch;
  logic [ERR_WIDTH-1:0] err_inc;
  logic [C_CNT_W-1:0]   n_clamped;
  logic [C_CNT_W-1:0]   wbi_next;

  always_comb begin
    // Register-0 writes are filtered out entirely when IGNORE_R0 is set.
    wb_acc    = wb.wb_en && !((IGNORE_R0 != 0) && (wb.wb_reg == '0));
    // wbi_q < N <= DEPTH whenever this is used, so the index is in range.
    mismatch  = ({wb.wb_reg, wb.wb_data} != table_q[wbi_q[C_IDX_W-1:0]]);
    err_inc   = (&err_q) ? err_q : err_q + 1'b1;
    n_clamped = (num_expected > C_CNT_W'(DEPTH)) ? C_CNT_W'(DEPTH) : num_expected;
    wbi_next  = wbi_q + 1'b1;

    state_d = state_q;
    n_d     = n_q;
    err_d   = err_q;
    wbi_d   = wbi_q;
    fev_d   = fev_q;
    fei_d   = fei_q;
    tmo_d   = tmo_q;

    if (state_q == ST_RUN) begin
      if (wb_acc) begin
        tmo_d = '0;
        wbi_d = wbi_next;
        if (mismatch) begin
          err_d = err_inc;
          if (!fev_q) begin
            fev_d = 1'b1;
            fei_d = wbi_q[C_IDX_W-1:0];
          end
        end
        // Verdict uses the count including this compare.
        if (wbi_next == n_q) begin
          state_d = (err_d != '0) ? ST_FAIL : ST_PASS;
        end
      end else begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == C_TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_TIMEOUT;
        end
      end
    end else if (start) begin
      n_d     = n_clamped;
      err_d   = '0;
      wbi_d   = '0;
      fev_d   = 1'b0;
      fei_d   = '0;
      tmo_d   = '0;
      state_d = (n_clamped == '0) ? ST_PASS : ST_RUN;
    end else if ((state_q == ST_PASS || state_q == ST_FAIL) && wb_acc) begin
      // Writebacks beyond the expected trace spoil a finished run.
      err_d   = err_inc;
      state_d = ST_FAIL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      err_q      <= '0;
      wbi_q      <= '0;
      fev_q      <= 1'b0;
      fei_q      <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      err_q      <= err_d;
      wbi_q      <= wbi_d;
      fev_q      <= fev_d;
      fei_q      <= fei_d;
      tmo_q      <= tmo_d;
      busy_q     <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
      pass_q     <= (state_d == ST_PASS);
      tmo_flag_q <= (state_d == ST_TIMEOUT);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && state_q == ST_IDLE && load_en) begin
      table_q[load_addr] <= {load_reg, load_data};
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timed_out       = tmo_flag_q;
  assign err_count       = err_q;
  assign wb_index        = wbi_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_trace_checker
// Description : Directed, table-driven bench for wb_trace_checker with a few
//               hand-written multi-cycle sequences (reset mid-run,
//               load+start in one cycle, error saturation with N clamping).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_trace_checker;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int DEP = 16;

  logic clock = 1'b0;
  logic reset;
  logic load_en;
  logic [3:0]  load_addr;
  logic [RW-1:0] load_reg;
  logic [DW-1:0] load_data;
  logic [4:0]  num_expected;
  logic start;
  logic busy, done, pass, timed_out;
  logic [1:0] err_count;
  logic [4:0] wb_index;
  logic first_err_valid;
  logic [3:0] first_err_idx;

  int total = 0;
  int bad   = 0;

  wb_trace_checker_if #(.REG_ADDR_WIDTH(RW), .DATA_WIDTH(DW)) wb_if ();

  wb_trace_checker #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .DEPTH(DEP),
    .TIMEOUT_CYCLES(8), .ERR_WIDTH(2), .IGNORE_R0(1)
  ) dut (
    .clock(clock), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_reg(load_reg), .load_data(load_data),
    .num_expected(num_expected), .start(start),
    .wb(wb_if.slave),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
    .err_count(err_count), .wb_index(wb_index),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
  );

  always #5 clock = ~clock;

  // flags = {busy, done, pass, timed_out}
  typedef struct {
    logic        ld;
    logic [3:0]  la;
    logic [4:0]  lr;
    logic [31:0] ldat;
    logic [4:0]  ne;
    logic        st;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [3:0]  flags;
    logic [1:0]  err;
    logic [4:0]  wbi;
    logic        fev;
    logic [3:0]  fei;
  } vec_t;

  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_RUN  = 4'b1000;
  localparam logic [3:0] F_PASS = 4'b0110;
  localparam logic [3:0] F_BAD  = 4'b0100;
  localparam logic [3:0] F_TMO  = 4'b0101;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(logic ld, logic [3:0] la, logic [4:0] lr, logic [31:0] ldat,
                              logic [4:0] ne, logic st,
                              logic we, logic [4:0] wr, logic [31:0] wd,
                              logic [3:0] flags, logic [1:0] err, logic [4:0] wbi,
                              logic fev, logic [3:0] fei);
    vec_t v;
    v.ld = ld; v.la = la; v.lr = lr; v.ldat = ldat; v.ne = ne; v.st = st;
    v.we = we; v.wr = wr; v.wd = wd; v.flags = flags; v.err = err; v.wbi = wbi;
    v.fev = fev; v.fei = fei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] flags, input logic [1:0] err,
                         input logic [4:0] wbi, input logic fev, input logic [3:0] fei);
    chk({tag, ".flags"}, {28'd0, busy, done, pass, timed_out}, {28'd0, flags});
    chk({tag, ".err"},   {30'd0, err_count}, {30'd0, err});
    chk({tag, ".wbi"},   {27'd0, wb_index}, {27'd0, wbi});
    chk({tag, ".fev"},   {31'd0, first_err_valid}, {31'd0, fev});
    chk({tag, ".fei"},   {28'd0, first_err_idx}, {28'd0, fei});
  endtask

  task automatic drive(input logic ld, input logic [3:0] la, input logic [4:0] lr,
                       input logic [31:0] ldat, input logic [4:0] ne, input logic st,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd);
    load_en = ld; load_addr = la; load_reg = lr; load_data = ldat;
    num_expected = ne; start = st;
    wb_if.wb_en = we; wb_if.wb_reg = wr; wb_if.wb_data = wd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Table r1=5, r2=7, r3=12; all-match, extra writeback, mismatch with r0
    // filter, N=0, timeout, and ignored writes/loads in TIMEOUT.
    vecs[0]  = mk(1,0,1,5,   0,0, 0,0,0,   F_IDLE,0,0,0,0);
    vecs[1]  = mk(1,1,2,7,   0,0, 0,0,0,   F_IDLE,0,0,0,0);
    vecs[2]  = mk(1,2,3,12,  0,0, 0,0,0,   F_IDLE,0,0,0,0);
    vecs[3]  = mk(0,0,0,0,   3,1, 0,0,0,   F_RUN, 0,0,0,0);
    vecs[4]  = mk(0,0,0,0,   0,0, 1,1,5,   F_RUN, 0,1,0,0);
    vecs[5]  = mk(0,0,0,0,   0,0, 1,2,7,   F_RUN, 0,2,0,0);
    vecs[6]  = mk(0,0,0,0,   0,0, 1,3,12,  F_PASS,0,3,0,0);
    vecs[7]  = mk(0,0,0,0,   0,0, 1,4,1,   F_BAD, 1,3,0,0);
    vecs[8]  = mk(0,0,0,0,   3,1, 0,0,0,   F_RUN, 0,0,0,0);
    vecs[9]  = mk(0,0,0,0,   0,0, 1,1,5,   F_RUN, 0,1,0,0);
    vecs[10] = mk(0,0,0,0,   0,0, 1,0,99,  F_RUN, 0,1,0,0);
    vecs[11] = mk(0,0,0,0,   0,0, 1,2,8,   F_RUN, 1,2,1,1);
    vecs[12] = mk(0,0,0,0,   0,0, 1,3,12,  F_BAD, 1,3,1,1);
    vecs[13] = mk(0,0,0,0,   0,0, 0,0,0,   F_BAD, 1,3,1,1);
    vecs[14] = mk(0,0,0,0,   0,0, 1,1,5,   F_BAD, 2,3,1,1);
    vecs[15] = mk(0,0,0,0,   0,1, 0,0,0,   F_PASS,0,0,0,0);
    vecs[16] = mk(0,0,0,0,   2,1, 0,0,0,   F_RUN, 0,0,0,0);
    vecs[17] = mk(0,0,0,0,   0,0, 1,1,5,   F_RUN, 0,1,0,0);
    for (int i = 18; i <= 24; i++)
      vecs[i] = mk(0,0,0,0,  0,0, 0,0,0,   F_RUN, 0,1,0,0);
    vecs[25] = mk(0,0,0,0,   0,0, 0,0,0,   F_TMO, 0,1,0,0);
    vecs[26] = mk(0,0,0,0,   0,0, 1,2,7,   F_TMO, 0,1,0,0);
    vecs[27] = mk(1,0,9,9,   0,0, 0,0,0,   F_TMO, 0,1,0,0);
    vecs[28] = mk(0,0,0,0,   1,1, 0,0,0,   F_RUN, 0,0,0,0);
    vecs[29] = mk(0,0,0,0,   0,0, 1,1,5,   F_PASS,0,1,0,0);

    reset = 1'b1;
    idle_in();
    tick();
    tick();
    chk_all("reset", F_IDLE, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ld, vecs[i].la, vecs[i].lr, vecs[i].ldat, vecs[i].ne, vecs[i].st,
            vecs[i].we, vecs[i].wr, vecs[i].wd);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].flags, vecs[i].err, vecs[i].wbi,
              vecs[i].fev, vecs[i].fei);
    end

    // Reset mid-run abandons the run but keeps the table.
    drive(0,0,0,0, 3,1, 0,0,0); tick();
    drive(0,0,0,0, 0,0, 1,1,5); tick();
    chk_all("mid.run", F_RUN, 0, 1, 0, 0);
    idle_in(); reset = 1'b1; tick(); reset = 1'b0;
    chk_all("mid.reset", F_IDLE, 0, 0, 0, 0);
    drive(0,0,0,0, 3,1, 0,0,0); tick();
    drive(0,0,0,0, 0,0, 1,1,5);  tick();
    drive(0,0,0,0, 0,0, 1,2,7);  tick();
    drive(0,0,0,0, 0,0, 1,3,12); tick();
    chk_all("mid.rerun", F_PASS, 0, 3, 0, 0);

    // Load and start in the same cycle; entry must be compared next cycle.
    idle_in(); reset = 1'b1; tick(); reset = 1'b0;
    drive(1,0,7,70, 1,1, 0,0,0); tick();
    drive(0,0,0,0,  0,0, 1,7,70); tick();
    chk_all("ldst", F_PASS, 0, 1, 0, 0);

    // Saturation with clamping: N=20 clamps to 16, all writebacks wrong.
    idle_in(); reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < DEP; i++) begin
      drive(1, 4'(i), 5'(i+1), 32'(i*3), 0, 0, 0, 0, 0);
      tick();
    end
    drive(0,0,0,0, 20,1, 0,0,0); tick();
    chk_all("sat.start", F_RUN, 0, 0, 0, 0);
    for (int i = 0; i < DEP; i++) begin
      drive(0,0,0,0, 0,0, 1, 5'(i+1), 32'(i*3+1));
      tick();
      chk_all($sformatf("sat%0d", i), (i == DEP-1) ? F_BAD : F_RUN,
              (i >= 2) ? 2'd3 : 2'(i+1), 5'(i+1), 1'b1, 4'd0);
    end
    idle_in(); tick();
    chk_all("sat.hold", F_BAD, 3, 16, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
- Synthesizable, self-checking monitor for the single-cycle CPU skeleton's register-file writeback port (write enable, write register, write data).
- Compares each writeback against a loadable table of expected (register, data) pairs.
- Counts mismatches and flags completion, pass/fail and timeout, so directed CPU tests are judged in hardware rather than left to a bench with no checks.
- Sits beside the skeleton; observes only, never drives CPU signals.

Parameters:
DATA_WIDTH, 32, writeback data width
REG_ADDR_WIDTH, 5, register index width
DEPTH, 16, expected-table entries
TIMEOUT_CYCLES, 1024, max consecutive RUN cycles without an accepted writeback
ERR_WIDTH, 8, error counter width (saturating)
IGNORE_R0, 1, 1 = writebacks to register 0 are not checked or counted

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
load_en  in  1  write one expected entry (IDLE only)
load_addr  in  $clog2(DEPTH)  table index
load_reg  in  REG_ADDR_WIDTH  expected register
load_data  in  DATA_WIDTH  expected data
num_expected  in  $clog2(DEPTH+1)  entries to check, sampled on start
start  in  1  begin a run
wb_en  in  1  CPU ctrl_writeEnable
wb_reg  in  REG_ADDR_WIDTH  CPU ctrl_writeReg
wb_data  in  DATA_WIDTH  CPU data_writeReg
busy  out  1  state is RUN
done  out  1  state is PASS, FAIL or TIMEOUT
pass  out  1  state is PASS
timed_out  out  1  state is TIMEOUT
err_count  out  ERR_WIDTH  mismatches plus extra writebacks, saturating
wb_index  out  $clog2(DEPTH+1)  accepted writebacks this run
first_err_valid  out  1  at least one mismatch recorded
first_err_idx  out  $clog2(DEPTH)  table index of first mismatch

Behaviour:
- All state updates on the rising clock edge. Outputs are registered or decoded from registered state.
- Reset (sync, active-high):
  - State goes to IDLE.
  - busy, done, pass, timed_out, err_count, wb_index, first_err_valid and first_err_idx are all 0.
  - Table contents are retained.
  - Reset mid-run abandons the run.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT.
- Load:
  - load_en in IDLE writes table[load_addr] = {load_reg, load_data}.
  - Ignored in every other state.
- Start:
  - Accepted in IDLE, PASS, FAIL or TIMEOUT; ignored in RUN.
  - On accept, latch N = min(num_expected, DEPTH).
  - Clear err_count, wb_index, first_err_valid, first_err_idx and the timeout counter.
  - Go to RUN; if N == 0, go directly to PASS.
- Load and start in the same IDLE cycle: both take effect, and the entry is valid for comparison from the next cycle.
- Accepted writeback: wb_en=1 and NOT (IGNORE_R0 and wb_reg==0).
- In RUN, each accepted writeback:
  - Compare {wb_reg, wb_data} to table[wb_index].
  - On mismatch: err_count += 1 (saturating at all-ones). If first_err_valid==0, set first_err_valid=1 and first_err_idx=wb_index.
  - wb_index += 1 and the timeout counter clears.
  - Results are visible the cycle after the sampling edge.
- Completion: when the accepted writeback makes wb_index reach N, go to FAIL if the final err_count (including this compare) > 0, else PASS. done rises one cycle after the last writeback's edge.
- Timeout: in RUN, the timeout counter increments every cycle without an accepted writeback. On reaching TIMEOUT_CYCLES, go to TIMEOUT (done=1, pass=0, timed_out=1); err_count and wb_index hold.
- In PASS or FAIL, any further accepted writeback:
  - err_count += 1 (saturating); state becomes FAIL.
  - wb_index does not advance.
- In TIMEOUT and IDLE, writebacks are ignored.
- Rejected register-0 writes never affect the counters or the timeout counter (the timeout counter still increments that cycle).

Test Plan:
- All-match: load 3 entries (r1=5, r2=7, r3=12), N=3, start, drive the matching writebacks on consecutive cycles → wb_index=3, done=1, pass=1, err_count=0 one cycle after the third.
- Single mismatch plus r0 filter: same table; second writeback has data 8; a write r0=99 is inserted between writebacks → FAIL, err_count=1, first_err_valid=1, first_err_idx=1, wb_index=3.
- Timeout: TIMEOUT_CYCLES=8, N=2, one correct writeback then idle → timed_out=1 exactly 8 cycles after that writeback's edge, wb_index=1, pass=0.
- Extra writeback after PASS: complete the all-match run, then one more write r4=1 → state FAIL, err_count=1, wb_index stays 3.
- Saturation and clamping: ERR_WIDTH=2, DEPTH=16, num_expected=20 (clamped N=16), all writebacks wrong → err_count holds at 3, FAIL after 16 writebacks.
- Reset mid-run and N=0: assert reset after 1 of 3 writebacks → all outputs 0, IDLE; restart with same table → passes. start with num_expected=0 → pass=1 next cycle.
